// File: rtl/seg_scan_mux.sv
// Time-multiplexed scanner for a common-anode seven-segment display: picks one
// nibble per slot for the downstream decoder and drives the digit anodes itself.
module seg_scan_mux #(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_en,
  output logic [3:0]            num_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     digit_an_n,
  output logic                  frame_start
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VW = 4 * DIGITS;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [IW-1:0]     idx_reg, idx_next;
  logic [VW-1:0]     disp_val_reg, disp_val_next;
  logic [DIGITS-1:0] disp_dp_reg, disp_dp_next;
  logic [VW-1:0]     pend_val_reg, pend_val_next;
  logic [DIGITS-1:0] pend_dp_reg, pend_dp_next;
  logic              pend_valid_reg, pend_valid_next;

  logic [3:0]        num_reg, num_next;
  logic              dp_reg, dp_next;
  logic [DIGITS-1:0] an_reg, an_next;
  logic              fs_reg, fs_next;

  logic              slot_wrap;
  logic              frame_wrap;
  logic              suppress_sel;
  logic              lit;
  logic [3:0]        disp_nib [DIGITS];
  logic [DIGITS-1:0] suppress;

  // A digit is blank-suppressed only if it and everything above it is zero
  // and its own decimal point is off; digit 0 always shows.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign disp_nib[gi] = disp_val_reg[4*gi +: 4];
      if (gi == 0) begin : g_lsd
        assign suppress[gi] = 1'b0;
      end else begin : g_upper
        assign suppress[gi] = lz_en && (disp_val_reg[VW-1:4*gi] == '0) && !disp_dp_reg[gi];
      end
    end
  endgenerate

  always_comb begin
    slot_wrap  = (cnt_reg == CNT_LAST);
    frame_wrap = slot_wrap && (idx_reg == IDX_LAST);
    cnt_next   = slot_wrap ? '0 : cnt_reg + 1'b1;
    idx_next   = idx_reg;
    if (slot_wrap) begin
      idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    end
  end

  // Display only changes at the frame boundary so a frame never mixes values;
  // a load on that same cycle re-arms pending for the following frame.
  always_comb begin
    disp_val_next   = disp_val_reg;
    disp_dp_next    = disp_dp_reg;
    pend_val_next   = pend_val_reg;
    pend_dp_next    = pend_dp_reg;
    pend_valid_next = pend_valid_reg;
    if (frame_wrap && pend_valid_reg) begin
      disp_val_next   = pend_val_reg;
      disp_dp_next    = pend_dp_reg;
      pend_valid_next = 1'b0;
    end
    if (load) begin
      pend_val_next   = value_in;
      pend_dp_next    = dp_in;
      pend_valid_next = 1'b1;
    end
  end

  always_comb begin
    num_next     = 4'h0;
    dp_next      = 1'b0;
    suppress_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_reg == IW'(i)) begin
        num_next     = disp_nib[i];
        dp_next      = disp_dp_reg[i];
        suppress_sel = suppress[i];
      end
    end
    lit = (int'(cnt_reg) >= BLANK_CYCLES) && !suppress_sel;
    for (int i = 0; i < DIGITS; i++) begin
      an_next[i] = !(lit && (idx_reg == IW'(i)));
    end
    fs_next = (idx_reg == '0) && (cnt_reg == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg        <= '0;
      idx_reg        <= '0;
      disp_val_reg   <= '0;
      disp_dp_reg    <= '0;
      pend_val_reg   <= '0;
      pend_dp_reg    <= '0;
      pend_valid_reg <= 1'b0;
      num_reg        <= 4'h0;
      dp_reg         <= 1'b0;
      an_reg         <= '1;
      fs_reg         <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      disp_val_reg   <= disp_val_next;
      disp_dp_reg    <= disp_dp_next;
      pend_val_reg   <= pend_val_next;
      pend_dp_reg    <= pend_dp_next;
      pend_valid_reg <= pend_valid_next;
      num_reg        <= num_next;
      dp_reg         <= dp_next;
      an_reg         <= an_next;
      fs_reg         <= fs_next;
    end
  end

  assign num_out     = num_reg;
  assign dp_out      = dp_reg;
  assign digit_an_n  = an_reg;
  assign frame_start = fs_reg;

endmodule
